// File: rtl/spi_flash_word_reader.sv
// SPI mode-0 flash read engine: fetches 32-bit words with command 0x03 and
// keeps chip select low between sequential addresses so reads can stream.
module spi_flash_word_reader #(
    parameter int CLK_DIV  = 2,
    parameter int CS_HIGH  = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic        clock,
    input  logic        resetb,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [23:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        flash_csb,
    output logic        flash_clk,
    output logic        flash_io0,
    output logic        flash_io0_oeb,
    input  logic        flash_io1,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, RESP, HOLD, DESEL} state_t;

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] CS_W      = 16'(CS_HIGH);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_MAX - 1);

    state_t      state_reg;
    logic [15:0] div_cnt_reg;
    logic [4:0]  bit_cnt_reg;
    logic        start_reg;
    logic        sck_reg;
    logic        csb_reg;
    logic        io0_reg;
    logic        ready_reg;
    logic        rsp_valid_reg;
    logic [31:0] rsp_data_reg;
    logic [31:0] tx_reg;
    logic [31:0] rx_reg;
    logic [23:0] addr_reg;
    logic [15:0] hold_cnt_reg;
    logic [15:0] cs_cnt_reg;
    logic        busy_reg;

    logic [23:0] addr_in;
    logic [23:0] next_addr;
    logic        seq_hit;
    logic        hold_last;
    logic        accept;
    logic        phase_end;
    logic [4:0]  last_idx;
    logic        bit_last;
    logic [31:0] rx_swapped;

    assign addr_in   = req_addr & 24'hFFFFFC;
    assign next_addr = addr_reg + 24'd4;
    assign seq_hit   = (addr_in == next_addr);
    assign hold_last = (hold_cnt_reg == HOLD_LAST);
    assign phase_end = (div_cnt_reg == DIV_LAST);
    assign bit_last  = (bit_cnt_reg == last_idx);

    // In HOLD only a sequential address may handshake, and never on the
    // timeout cycle, so a refused request is never seen as accepted.
    assign req_ready = ready_reg & ((state_reg != HOLD) | (seq_hit & ~hold_last));
    assign accept    = req_valid & req_ready;

    always_comb begin
        last_idx = 5'd31;
        case (state_reg)
            CMD:     last_idx = 5'd7;
            ADDR:    last_idx = 5'd23;
            default: last_idx = 5'd31;
        endcase
    end

    // The first byte received sits in rx_reg[31:24]; it belongs in the low lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_swap
            assign rx_swapped[gi*8 +: 8] = rx_reg[(3-gi)*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clock) begin
        if (!resetb) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= 5'd0;
            start_reg     <= 1'b0;
            csb_reg       <= 1'b1;
            io0_reg       <= 1'b0;
            ready_reg     <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= 32'd0;
            tx_reg        <= 32'd0;
            rx_reg        <= 32'd0;
            addr_reg      <= 24'd0;
            hold_cnt_reg  <= 16'd0;
            cs_cnt_reg    <= CS_W;
            busy_reg      <= 1'b0;
            // A high SCK phase in progress runs to full length before dropping.
            if (sck_reg && !phase_end) begin
                div_cnt_reg <= div_cnt_reg + 16'd1;
            end else begin
                sck_reg     <= 1'b0;
                div_cnt_reg <= 16'd0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg   <= CMD;
                        ready_reg   <= 1'b0;
                        busy_reg    <= 1'b1;
                        start_reg   <= 1'b1;
                        addr_reg    <= addr_in;
                        tx_reg      <= {8'h03, addr_in};
                        bit_cnt_reg <= 5'd0;
                        div_cnt_reg <= 16'd0;
                        sck_reg     <= 1'b0;
                    end else begin
                        ready_reg <= 1'b1;
                    end
                end
                CMD, ADDR, DATA: begin
                    if (start_reg) begin
                        start_reg   <= 1'b0;
                        csb_reg     <= 1'b0;
                        io0_reg     <= tx_reg[31];
                        div_cnt_reg <= 16'd0;
                    end else if (!phase_end) begin
                        div_cnt_reg <= div_cnt_reg + 16'd1;
                    end else begin
                        div_cnt_reg <= 16'd0;
                        if (!sck_reg) begin
                            sck_reg <= 1'b1;
                            if (state_reg == DATA)
                                rx_reg <= {rx_reg[30:0], flash_io1};
                        end else begin
                            sck_reg <= 1'b0;
                            // Outgoing bits advance only on the falling edge.
                            if (state_reg == DATA || (state_reg == ADDR && bit_last)) begin
                                io0_reg <= 1'b0;
                            end else begin
                                io0_reg <= tx_reg[30];
                                tx_reg  <= {tx_reg[30:0], 1'b0};
                            end
                            if (bit_last) begin
                                bit_cnt_reg <= 5'd0;
                                case (state_reg)
                                    CMD:  state_reg <= ADDR;
                                    ADDR: state_reg <= DATA;
                                    default: begin
                                        state_reg     <= RESP;
                                        rsp_valid_reg <= 1'b1;
                                        rsp_data_reg  <= rx_swapped;
                                    end
                                endcase
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 5'd1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        if (HOLD_MAX > 0) begin
                            state_reg    <= HOLD;
                            ready_reg    <= 1'b1;
                            hold_cnt_reg <= 16'd0;
                        end else begin
                            state_reg  <= DESEL;
                            csb_reg    <= 1'b1;
                            cs_cnt_reg <= 16'd0;
                        end
                    end
                end
                HOLD: begin
                    if (accept) begin
                        state_reg   <= DATA;
                        ready_reg   <= 1'b0;
                        addr_reg    <= addr_in;
                        bit_cnt_reg <= 5'd0;
                        div_cnt_reg <= 16'd0;
                        sck_reg     <= 1'b0;
                    end else if (req_valid || hold_last) begin
                        state_reg  <= DESEL;
                        ready_reg  <= 1'b0;
                        csb_reg    <= 1'b1;
                        io0_reg    <= 1'b0;
                        cs_cnt_reg <= 16'd0;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 16'd1;
                    end
                end
                DESEL: begin
                    if (cs_cnt_reg + 16'd1 >= CS_W) begin
                        state_reg  <= IDLE;
                        busy_reg   <= 1'b0;
                        ready_reg  <= 1'b1;
                        cs_cnt_reg <= CS_W;
                    end else begin
                        cs_cnt_reg <= cs_cnt_reg + 16'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    csb_reg   <= 1'b1;
                    sck_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign rsp_valid     = rsp_valid_reg;
    assign rsp_data      = rsp_data_reg;
    assign flash_csb     = csb_reg;
    assign flash_clk     = sck_reg;
    assign flash_io0     = io0_reg;
    assign flash_io0_oeb = csb_reg;
    assign busy          = busy_reg;

endmodule

// File: tb/tb_spi_flash_word_reader.sv
// Directed bench for spi_flash_word_reader: a behavioural SPI flash answers
// reads from a fixed byte image while a linear sequence checks each scenario.
module tb_spi_flash_word_reader;

    localparam int CLK_DIV  = 1;
    localparam int CS_HIGH  = 4;
    localparam int HOLD_MAX = 16;

    logic        clock;
    logic        resetb;
    logic        req_valid;
    logic        req_ready;
    logic [23:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        flash_csb;
    logic        flash_clk;
    logic        flash_io0;
    logic        flash_io0_oeb;
    logic        io1;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    spi_flash_word_reader #(
        .CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH), .HOLD_MAX(HOLD_MAX)
    ) dut (
        .clock(clock), .resetb(resetb),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .flash_csb(flash_csb), .flash_clk(flash_clk), .flash_io0(flash_io0),
        .flash_io0_oeb(flash_io0_oeb), .flash_io1(io1), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        case (a)
            24'h000100: mem_byte = 8'h11;
            24'h000101: mem_byte = 8'h22;
            24'h000102: mem_byte = 8'h33;
            24'h000103: mem_byte = 8'h44;
            default:    mem_byte = (a[7:0] * 8'd7) ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [23:0] a);
        return {mem_byte(a + 24'd3), mem_byte(a + 24'd2), mem_byte(a + 24'd1), mem_byte(a)};
    endfunction

    function automatic logic data_bit(input logic [23:0] base, input int k);
        logic [7:0] b;
        b = mem_byte(base + 24'(k / 8));
        return b[3'(7 - (k % 8))];
    endfunction

    // Flash model: shifts in cmd+addr on SCK rise, drives data on SCK fall.
    int          rcnt = 0;
    int          ncmd = 0;
    int          nfall = 0;
    int          last_high = 0;
    time         t_rise = 0;
    logic [31:0] sh = 32'd0;
    logic [7:0]  last_cmd = 8'd0;
    logic [23:0] last_addr = 24'd0;

    always @(posedge flash_clk or posedge flash_csb) begin
        if (flash_csb) begin
            rcnt <= 0;
        end else begin
            if (rcnt < 32) begin
                sh <= {sh[30:0], flash_io0};
                if (rcnt == 31) begin
                    last_cmd  <= sh[30:23];
                    last_addr <= {sh[22:0], flash_io0};
                    ncmd      <= ncmd + 1;
                end
            end
            rcnt <= rcnt + 1;
        end
    end

    always @(negedge flash_clk) begin
        if (!flash_csb && rcnt >= 32)
            io1 <= data_bit(last_addr, rcnt - 32);
    end

    always @(posedge flash_csb) t_rise <= $time;
    always @(negedge flash_csb) begin
        nfall     <= nfall + 1;
        last_high <= int'(($time - t_rise) / 10);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic [23:0] a, input int exp_lat, input logic [31:0] exp_d);
        int n;
        int lat;
        req_valid = 1'b1;
        req_addr  = a;
        n = 0;
        while (!req_ready && n < 300) begin
            step();
            n++;
        end
        chk("accept_in_time", 32'(n < 300), 32'd1);
        step();
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 600) begin
            step();
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("rsp_data", rsp_data, exp_d);
        $display("read addr=0x%06h latency=%0d data=0x%08h", a, lat, rsp_data);
    endtask

    task automatic wait_desel(output int n);
        n = 0;
        while (!flash_csb && n < 200) begin
            step();
            n++;
        end
    endtask

    int          n;
    int          f0;
    int          c0;
    int          rise_cyc;
    logic [31:0] held;

    initial begin
        resetb    = 1'b0;
        req_valid = 1'b0;
        req_addr  = 24'd0;
        rsp_ready = 1'b1;
        io1       = 1'b0;
        repeat (3) step();
        chk("rst_csb", 32'(flash_csb), 32'd1);
        chk("rst_clk", 32'(flash_clk), 32'd0);
        chk("rst_io0", 32'(flash_io0), 32'd0);
        chk("rst_oeb", 32'(flash_io0_oeb), 32'd1);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        resetb = 1'b1;
        step();
        chk("ready_after_reset", 32'(req_ready), 32'd1);

        // Single read, then HOLD times out with nothing requested.
        c0 = ncmd;
        do_req(24'h000100, 129, 32'h44332211);
        chk("single_cmd", 32'(last_cmd), 32'h03);
        chk("single_addr", 32'(last_addr), 32'h000100);
        chk("single_ncmd", 32'(ncmd - c0), 32'd1);
        chk("single_oeb", 32'(flash_io0_oeb), 32'd0);
        wait_desel(n);
        chk("hold_timeout", 32'(n), 32'(HOLD_MAX + 1));
        $display("hold timeout after %0d cycles", n);

        // Three sequential words in one chip-select window.
        f0 = nfall;
        c0 = ncmd;
        do_req(24'h000100, 129, 32'h44332211);
        do_req(24'h000104, 64, word_at(24'h000104));
        do_req(24'h000108, 64, word_at(24'h000108));
        chk("stream_csb_windows", 32'(nfall - f0), 32'd1);
        chk("stream_ncmd", 32'(ncmd - c0), 32'd1);

        // Non-sequential request in HOLD: refused, deselect, fresh command.
        req_valid = 1'b1;
        req_addr  = 24'h000200;
        step();
        chk("nonseq_refused", 32'(req_ready), 32'd0);
        c0 = ncmd;
        do_req(24'h000200, 129, word_at(24'h000200));
        chk("nonseq_cs_high", 32'(last_high >= CS_HIGH), 32'd1);
        chk("nonseq_cmd", 32'(last_cmd), 32'h03);
        chk("nonseq_addr", 32'(last_addr), 32'h000200);
        chk("nonseq_ncmd", 32'(ncmd - c0), 32'd1);
        wait_desel(n);

        // Backpressure: response held for 20 cycles with a sequential request pending.
        rsp_ready = 1'b0;
        do_req(24'h000300, 129, word_at(24'h000300));
        held      = rsp_data;
        req_valid = 1'b1;
        req_addr  = 24'h000304;
        for (int i = 0; i < 20; i++) begin
            step();
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_data", rsp_data, held);
            chk("bp_sck_low", 32'(flash_clk), 32'd0);
            chk("bp_csb_low", 32'(flash_csb), 32'd0);
            chk("bp_no_accept", 32'(req_ready), 32'd0);
        end
        $display("backpressure held data=0x%08h for 20 cycles", held);
        rsp_ready = 1'b1;
        do_req(24'h000304, 64, word_at(24'h000304));
        wait_desel(n);

        // Address wrap counts as sequential.
        f0 = nfall;
        c0 = ncmd;
        do_req(24'hFFFFFC, 129, word_at(24'hFFFFFC));
        do_req(24'h000000, 64, word_at(24'h000000));
        chk("wrap_csb_windows", 32'(nfall - f0), 32'd1);
        chk("wrap_ncmd", 32'(ncmd - c0), 32'd1);
        chk("wrap_addr", 32'(last_addr), 32'hFFFFFC);
        wait_desel(n);
        chk("wrap_timeout", 32'(n), 32'(HOLD_MAX + 1));

        // Reset held 5 cycles in the middle of the address phase.
        req_valid = 1'b1;
        req_addr  = 24'h000400;
        n = 0;
        while (!req_ready && n < 300) begin
            step();
            n++;
        end
        step();
        req_valid = 1'b0;
        repeat (30) step();
        chk("mid_addr_busy", 32'(busy), 32'd1);
        chk("mid_addr_csb", 32'(flash_csb), 32'd0);
        resetb = 1'b0;
        step();
        chk("abort_csb", 32'(flash_csb), 32'd1);
        rise_cyc = cyc;
        repeat (4) step();
        chk("abort_clk", 32'(flash_clk), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd0);
        resetb = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            step();
            n++;
        end
        chk("abort_ready_returns", 32'(n < 50), 32'd1);
        chk("abort_cs_high", 32'((cyc - rise_cyc) >= CS_HIGH), 32'd1);
        $display("reset abort: ready again %0d cycles after csb rose", cyc - rise_cyc);
        c0 = ncmd;
        do_req(24'h000100, 129, 32'h44332211);
        chk("post_reset_cmd", 32'(last_cmd), 32'h03);
        chk("post_reset_addr", 32'(last_addr), 32'h000100);
        chk("post_reset_ncmd", 32'(ncmd - c0), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
